lieat_axi_arbiter: RTL and testbench

- Shares one external AXI-lite master port between the icache (read-only) and the dcache (read and write).
- Allows one outstanding single-beat transaction at a time. Upstream addresses and data are latched, then replayed on the master port. The response is routed back to the owning requester.
- Sits between the fetch/exec cache AXI ports and the SoC bus.

---
 rtl/lieat_axi_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_lieat_axi_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_axi_arbiter.sv
// Shares one AXI-lite master between icache reads and dcache reads/writes, one single-beat transaction at a time.
// Accept is combinational in IDLE; master valid follows a cycle later; responses pass straight through to the owner.
module lieat_axi_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            icache_axi_arvalid,
    output logic            icache_axi_arready,
    input  logic [XLEN-1:0] icache_axi_araddr,
    input  logic [2:0]      icache_axi_arsize,
    output logic            icache_axi_rvalid,
    input  logic            icache_axi_rready,
    output logic [XLEN-1:0] icache_axi_rdata,
    input  logic            dcache_axi_arvalid,
    output logic            dcache_axi_arready,
    input  logic [XLEN-1:0] dcache_axi_araddr,
    input  logic [2:0]      dcache_axi_arsize,
    output logic            dcache_axi_rvalid,
    input  logic            dcache_axi_rready,
    output logic [XLEN-1:0] dcache_axi_rdata,
    input  logic            dcache_axi_awvalid,
    output logic            dcache_axi_awready,
    input  logic [XLEN-1:0] dcache_axi_awaddr,
    input  logic [2:0]      dcache_axi_awsize,
    input  logic            dcache_axi_wvalid,
    output logic            dcache_axi_wready,
    input  logic [XLEN-1:0] dcache_axi_wdata,
    output logic            dcache_axi_bvalid,
    input  logic            dcache_axi_bready,
    output logic [1:0]      dcache_axi_bresp,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    output logic [XLEN-1:0] m_axi_araddr,
    output logic [2:0]      m_axi_arsize,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready,
    input  logic [XLEN-1:0] m_axi_rdata,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [XLEN-1:0] m_axi_awaddr,
    output logic [2:0]      m_axi_awsize,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    output logic [XLEN-1:0] m_axi_wdata,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready,
    input  logic [1:0]      m_axi_bresp,
    output logic            arb_busy,
    output logic [1:0]      arb_owner
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [2:0]      size;
        logic [XLEN-1:0] data;
    } req_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IC   = 2'b01;
    localparam logic [1:0] OWN_DC   = 2'b10;
    localparam logic [1:0] OWN_WR   = 2'b11;

    state_t     r_state;
    req_t       r_req;
    logic [1:0] r_owner;
    logic       r_rr_last;    // 1: dcache read was granted last
    logic       r_aw_done;
    logic       r_w_done;

    logic w_idle;
    logic w_wr_elig;
    logic w_gnt_wr;
    logic w_gnt_dc;
    logic w_gnt_ic;
    logic w_rd_data;
    logic w_wr_resp;
    logic w_ic_own;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_aw_done_n;
    logic w_w_done_n;

    assign w_idle    = (r_state == IDLE);
    assign w_wr_elig = dcache_axi_awvalid & dcache_axi_wvalid;
    assign w_gnt_wr  = w_idle & w_wr_elig;
    assign w_gnt_dc  = w_idle & ~w_wr_elig & dcache_axi_arvalid & (~icache_axi_arvalid | ~r_rr_last);
    assign w_gnt_ic  = w_idle & ~w_wr_elig & icache_axi_arvalid & ~w_gnt_dc;

    assign icache_axi_arready = w_gnt_ic;
    assign dcache_axi_arready = w_gnt_dc;
    assign dcache_axi_awready = w_gnt_wr;
    assign dcache_axi_wready  = w_gnt_wr;

    assign w_rd_data = (r_state == RD_DATA);
    assign w_wr_resp = (r_state == WR_RESP);
    assign w_ic_own  = (r_owner == OWN_IC);

    assign m_axi_arvalid = (r_state == RD_ADDR);
    assign m_axi_araddr  = r_req.addr;
    assign m_axi_arsize  = r_req.size;
    assign m_axi_rready  = w_rd_data & (w_ic_own ? icache_axi_rready : dcache_axi_rready);

    assign icache_axi_rvalid = w_rd_data & w_ic_own & m_axi_rvalid;
    assign dcache_axi_rvalid = w_rd_data & (r_owner == OWN_DC) & m_axi_rvalid;
    assign icache_axi_rdata  = m_axi_rdata;
    assign dcache_axi_rdata  = m_axi_rdata;

    // Address and data channels retire independently; the done flags remember which one already went.
    assign m_axi_awvalid = (r_state == WR_ADDR) & ~r_aw_done;
    assign m_axi_wvalid  = (r_state == WR_ADDR) & ~r_w_done;
    assign m_axi_awaddr  = r_req.addr;
    assign m_axi_awsize  = r_req.size;
    assign m_axi_wdata   = r_req.data;
    assign w_aw_fire     = m_axi_awvalid & m_axi_awready;
    assign w_w_fire      = m_axi_wvalid & m_axi_wready;
    assign w_aw_done_n   = r_aw_done | w_aw_fire;
    assign w_w_done_n    = r_w_done | w_w_fire;

    assign dcache_axi_bvalid = w_wr_resp & m_axi_bvalid;
    assign dcache_axi_bresp  = m_axi_bresp;
    assign m_axi_bready      = w_wr_resp & dcache_axi_bready;

    assign arb_busy  = ~w_idle;
    assign arb_owner = r_owner;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_owner   <= OWN_NONE;
            r_rr_last <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_wr) begin
                        r_req     <= '{addr: dcache_axi_awaddr, size: dcache_axi_awsize, data: dcache_axi_wdata};
                        r_owner   <= OWN_WR;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= WR_ADDR;
                    end else if (w_gnt_dc) begin
                        r_req.addr <= dcache_axi_araddr;
                        r_req.size <= dcache_axi_arsize;
                        r_owner    <= OWN_DC;
                        r_rr_last  <= 1'b1;
                        r_state    <= RD_ADDR;
                    end else if (w_gnt_ic) begin
                        r_req.addr <= icache_axi_araddr;
                        r_req.size <= icache_axi_arsize;
                        r_owner    <= OWN_IC;
                        r_rr_last  <= 1'b0;
                        r_state    <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        r_owner <= OWN_NONE;
                        r_state <= IDLE;
                    end
                end
                WR_ADDR: begin
                    if (w_aw_done_n && w_w_done_n) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= WR_RESP;
                    end else begin
                        r_aw_done <= w_aw_done_n;
                        r_w_done  <= w_w_done_n;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        r_owner <= OWN_NONE;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lieat_axi_arbiter.sv
// Bench for lieat_axi_arbiter: grant table, directed multi-cycle sequences, then random traffic
// against a transaction-level model of requesters, arbitration rules and an AXI-lite slave.
module tb_lieat_axi_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic            icache_axi_arvalid, icache_axi_arready, icache_axi_rvalid, icache_axi_rready;
    logic [XLEN-1:0] icache_axi_araddr, icache_axi_rdata;
    logic [2:0]      icache_axi_arsize;
    logic            dcache_axi_arvalid, dcache_axi_arready, dcache_axi_rvalid, dcache_axi_rready;
    logic [XLEN-1:0] dcache_axi_araddr, dcache_axi_rdata;
    logic [2:0]      dcache_axi_arsize;
    logic            dcache_axi_awvalid, dcache_axi_awready, dcache_axi_wvalid, dcache_axi_wready;
    logic [XLEN-1:0] dcache_axi_awaddr, dcache_axi_wdata;
    logic [2:0]      dcache_axi_awsize;
    logic            dcache_axi_bvalid, dcache_axi_bready;
    logic [1:0]      dcache_axi_bresp;
    logic            m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [XLEN-1:0] m_axi_araddr, m_axi_rdata;
    logic [2:0]      m_axi_arsize;
    logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [XLEN-1:0] m_axi_awaddr, m_axi_wdata;
    logic [2:0]      m_axi_awsize;
    logic            m_axi_bvalid, m_axi_bready;
    logic [1:0]      m_axi_bresp;
    logic            arb_busy;
    logic [1:0]      arb_owner;

    lieat_axi_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn),
        .icache_axi_arvalid(icache_axi_arvalid), .icache_axi_arready(icache_axi_arready),
        .icache_axi_araddr(icache_axi_araddr), .icache_axi_arsize(icache_axi_arsize),
        .icache_axi_rvalid(icache_axi_rvalid), .icache_axi_rready(icache_axi_rready),
        .icache_axi_rdata(icache_axi_rdata),
        .dcache_axi_arvalid(dcache_axi_arvalid), .dcache_axi_arready(dcache_axi_arready),
        .dcache_axi_araddr(dcache_axi_araddr), .dcache_axi_arsize(dcache_axi_arsize),
        .dcache_axi_rvalid(dcache_axi_rvalid), .dcache_axi_rready(dcache_axi_rready),
        .dcache_axi_rdata(dcache_axi_rdata),
        .dcache_axi_awvalid(dcache_axi_awvalid), .dcache_axi_awready(dcache_axi_awready),
        .dcache_axi_awaddr(dcache_axi_awaddr), .dcache_axi_awsize(dcache_axi_awsize),
        .dcache_axi_wvalid(dcache_axi_wvalid), .dcache_axi_wready(dcache_axi_wready),
        .dcache_axi_wdata(dcache_axi_wdata),
        .dcache_axi_bvalid(dcache_axi_bvalid), .dcache_axi_bready(dcache_axi_bready),
        .dcache_axi_bresp(dcache_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fmix(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic clr_inputs;
        icache_axi_arvalid = 0; icache_axi_araddr = '0; icache_axi_arsize = '0; icache_axi_rready = 0;
        dcache_axi_arvalid = 0; dcache_axi_araddr = '0; dcache_axi_arsize = '0; dcache_axi_rready = 0;
        dcache_axi_awvalid = 0; dcache_axi_awaddr = '0; dcache_axi_awsize = '0;
        dcache_axi_wvalid = 0; dcache_axi_wdata = '0; dcache_axi_bready = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
    endtask

    task automatic do_reset;
        rstn = 0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #2 rstn = 1;
    endtask

    // Complete single read from one requester with an immediately ready slave.
    task automatic do_read(input bit dc, input logic [31:0] addr, input logic [31:0] data);
        cyc();
        if (dc) begin dcache_axi_arvalid = 1; dcache_axi_araddr = addr; dcache_axi_arsize = 3'd2; end
        else    begin icache_axi_arvalid = 1; icache_axi_araddr = addr; icache_axi_arsize = 3'd2; end
        smp();
        chk("rd_accept_c0", dc ? dcache_axi_arready : icache_axi_arready, 1);
        cyc();
        icache_axi_arvalid = 0; dcache_axi_arvalid = 0; m_axi_arready = 1;
        smp();
        chk("rd_m_arvalid_c1", m_axi_arvalid, 1);
        chk("rd_m_araddr_c1", m_axi_araddr, addr);
        chk("rd_owner_c1", arb_owner, dc ? 2'b10 : 2'b01);
        cyc();
        m_axi_arready = 0;
        smp();
        chk("rd_arvalid_drop_c2", m_axi_arvalid, 0);
        cyc();
        m_axi_rvalid = 1; m_axi_rdata = data; icache_axi_rready = 1; dcache_axi_rready = 1;
        smp();
        chk("rd_rvalid_c3", dc ? dcache_axi_rvalid : icache_axi_rvalid, 1);
        chk("rd_other_rvalid_c3", dc ? icache_axi_rvalid : dcache_axi_rvalid, 0);
        chk("rd_rdata_c3", dc ? dcache_axi_rdata : icache_axi_rdata, data);
        chk("rd_m_rready_c3", m_axi_rready, 1);
        cyc();
        m_axi_rvalid = 0; icache_axi_rready = 0; dcache_axi_rready = 0;
        smp();
        chk("rd_idle_c4", arb_busy, 0);
        chk("rd_owner_none_c4", arb_owner, 0);
    endtask

    typedef struct {
        logic iv, dv, awv, wv;
        logic e_ir, e_dr, e_aw;
        logic [1:0] e_own;
    } vec_t;
    vec_t vt[10];

    // Random-phase model state
    bit          pi, pd, pw, pw_aw, pw_w;
    logic [31:0] pi_addr, pd_addr, pw_addr, pw_data;
    logic [2:0]  pi_size, pd_size, pw_size;
    bit          mb, ar_s, aw_s, w_s, rr_dc, b0;
    logic [1:0]  own;
    logic [31:0] m_addr, m_data;
    logic [2:0]  m_size;
    bit          s_rd, s_b;
    int          s_rd_dly, s_b_dly;
    logic [31:0] s_rdata;
    logic [1:0]  s_bresp;
    bit          e_i, e_d, e_w, rv_o, rv_n, rr_o;
    logic [31:0] rdat;
    int          n_done;
    logic [1:0]  owners[3];
    int          n_own;
    bit          prev_busy;

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};
        vt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
        vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

        clr_inputs();
        do_reset();
        smp();
        chk("rst_busy", arb_busy, 0);
        chk("rst_owner", arb_owner, 0);
        chk("rst_m_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
        chk("rst_up_readies", {icache_axi_arready, dcache_axi_arready, dcache_axi_awready, dcache_axi_wready}, 0);
        chk("rst_m_araddr", m_axi_araddr, 0);
        chk("rst_m_wdata", m_axi_wdata, 0);

        // Grant table, each entry from a fresh reset (icache counted as last read winner)
        for (int k = 0; k < 10; k++) begin
            do_reset();
            cyc();
            icache_axi_arvalid = vt[k].iv; icache_axi_araddr = 32'h1000_0000;
            dcache_axi_arvalid = vt[k].dv; dcache_axi_araddr = 32'h2000_0000;
            dcache_axi_awvalid = vt[k].awv; dcache_axi_awaddr = 32'h3000_0000;
            dcache_axi_wvalid = vt[k].wv;  dcache_axi_wdata = 32'h4444_4444;
            smp();
            chk($sformatf("tbl%0d_ic_arready", k), icache_axi_arready, vt[k].e_ir);
            chk($sformatf("tbl%0d_dc_arready", k), dcache_axi_arready, vt[k].e_dr);
            chk($sformatf("tbl%0d_awready", k), dcache_axi_awready, vt[k].e_aw);
            chk($sformatf("tbl%0d_wready", k), dcache_axi_wready, vt[k].e_aw);
            cyc();
            clr_inputs();
            smp();
            chk($sformatf("tbl%0d_owner", k), arb_owner, vt[k].e_own);
        end

        // Lone icache read with exact cycle timing
        do_reset();
        do_read(1'b0, 32'h8000_0000, 32'h1234_5678);

        // Both readers hold valid: dcache, icache, dcache
        do_reset();
        cyc();
        icache_axi_arvalid = 1; icache_axi_araddr = 32'h8000_0010;
        dcache_axi_arvalid = 1; dcache_axi_araddr = 32'h8000_0020;
        m_axi_arready = 1; m_axi_rvalid = 1; m_axi_rdata = 32'h5555_AAAA;
        icache_axi_rready = 1; dcache_axi_rready = 1;
        n_own = 0; prev_busy = 0;
        for (int k = 0; k < 9; k++) begin
            smp();
            if (arb_busy && !prev_busy && n_own < 3) begin
                owners[n_own] = arb_owner;
                n_own++;
            end
            prev_busy = arb_busy;
            cyc();
        end
        clr_inputs();
        chk("rr_grant_count", n_own, 3);
        if (n_own == 3) begin
            chk("rr_owner0", owners[0], 2'b10);
            chk("rr_owner1", owners[1], 2'b01);
            chk("rr_owner2", owners[2], 2'b10);
        end

        // Write with m_wready early and m_awready late
        do_reset();
        cyc();
        dcache_axi_awvalid = 1; dcache_axi_awaddr = 32'h8000_0100; dcache_axi_awsize = 3'd2;
        dcache_axi_wvalid = 1; dcache_axi_wdata = 32'hDEAD_BEEF;
        smp();
        chk("wr_accept_aw", dcache_axi_awready, 1);
        chk("wr_accept_w", dcache_axi_wready, 1);
        cyc();
        dcache_axi_awvalid = 0; dcache_axi_wvalid = 0; m_axi_wready = 1;
        smp();
        chk("wr_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        chk("wr_c1_awaddr", m_axi_awaddr, 32'h8000_0100);
        chk("wr_c1_wdata", m_axi_wdata, 32'hDEAD_BEEF);
        chk("wr_c1_owner", arb_owner, 2'b11);
        cyc();
        m_axi_wready = 0;
        smp();
        chk("wr_c2_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
        cyc();
        m_axi_awready = 1;
        smp();
        chk("wr_c3_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
        cyc();
        m_axi_awready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b00; dcache_axi_bready = 1;
        smp();
        chk("wr_c4_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
        chk("wr_c4_bvalid", dcache_axi_bvalid, 1);
        chk("wr_c4_bresp", dcache_axi_bresp, 2'b00);
        chk("wr_c4_m_bready", m_axi_bready, 1);
        cyc();
        clr_inputs();
        smp();
        chk("wr_c5_idle", arb_busy, 0);

        // Write beats a same-cycle icache read; read waits for the b handshake
        do_reset();
        cyc();
        dcache_axi_awvalid = 1; dcache_axi_wvalid = 1; dcache_axi_awaddr = 32'h8000_0200;
        icache_axi_arvalid = 1; icache_axi_araddr = 32'h8000_0300;
        smp();
        chk("pri_aw_first", dcache_axi_awready, 1);
        chk("pri_ic_wait0", icache_axi_arready, 0);
        cyc();
        dcache_axi_awvalid = 0; dcache_axi_wvalid = 0; m_axi_awready = 1; m_axi_wready = 1;
        smp();
        chk("pri_ic_wait1", icache_axi_arready, 0);
        cyc();
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b10;
        smp();
        chk("pri_ic_wait2", icache_axi_arready, 0);
        chk("pri_bresp_pass", dcache_axi_bresp, 2'b10);
        cyc();
        dcache_axi_bready = 1;
        smp();
        chk("pri_ic_wait3", icache_axi_arready, 0);
        cyc();
        m_axi_bvalid = 0; dcache_axi_bready = 0;
        smp();
        chk("pri_ic_grant", icache_axi_arready, 1);
        cyc();
        icache_axi_arvalid = 0;
        smp();
        chk("pri_ic_addr", m_axi_araddr, 32'h8000_0300);

        // icache backpressure on the data phase
        do_reset();
        cyc();
        icache_axi_arvalid = 1; icache_axi_araddr = 32'h8000_0400;
        smp();
        chk("bp_accept", icache_axi_arready, 1);
        cyc();
        icache_axi_arvalid = 0; m_axi_arready = 1;
        smp();
        cyc();
        m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rdata = 32'h0BAD_CAFE; icache_axi_rready = 0;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("bp_m_rready_low", m_axi_rready, 0);
            chk("bp_busy", arb_busy, 1);
            chk("bp_rvalid_fwd", icache_axi_rvalid, 1);
            cyc();
        end
        icache_axi_rready = 1;
        smp();
        chk("bp_m_rready_high", m_axi_rready, 1);
        chk("bp_rdata", icache_axi_rdata, 32'h0BAD_CAFE);
        cyc();
        clr_inputs();
        smp();
        chk("bp_done", arb_busy, 0);

        // Asynchronous reset during the master address phase
        do_reset();
        cyc();
        icache_axi_arvalid = 1; icache_axi_araddr = 32'h8000_0040;
        smp();
        chk("mr_accept", icache_axi_arready, 1);
        cyc();
        icache_axi_arvalid = 0;
        smp();
        chk("mr_pre_arvalid", m_axi_arvalid, 1);
        #1 rstn = 0;
        #1;
        chk("mr_arvalid", m_axi_arvalid, 0);
        chk("mr_owner", arb_owner, 0);
        chk("mr_busy", arb_busy, 0);
        chk("mr_m_araddr", m_axi_araddr, 0);
        @(posedge clk);
        #2 rstn = 1;
        do_read(1'b1, 32'h8000_0080, 32'hCAFE_F00D);

        // Random traffic against the transaction-level model
        do_reset();
        pi = 0; pd = 0; pw = 0; pw_aw = 0; pw_w = 0;
        mb = 0; own = 0; rr_dc = 0; ar_s = 0; aw_s = 0; w_s = 0;
        s_rd = 0; s_b = 0; s_rd_dly = 0; s_b_dly = 0; s_rdata = '0; s_bresp = '0;
        m_addr = '0; m_data = '0; m_size = '0; n_done = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!pi && $urandom_range(0, 3) == 0) begin
                pi = 1; pi_addr = $urandom; pi_size = 3'($urandom_range(0, 7));
            end
            if (!pd && $urandom_range(0, 3) == 0) begin
                pd = 1; pd_addr = $urandom; pd_size = 3'($urandom_range(0, 7));
            end
            if (!pw && $urandom_range(0, 4) == 0) begin
                pw = 1; pw_addr = $urandom; pw_data = $urandom; pw_size = 3'($urandom_range(0, 7));
                pw_aw = 1'($urandom_range(0, 1)); pw_w = 1'($urandom_range(0, 1));
            end else if (pw) begin
                if (!pw_aw && $urandom_range(0, 1) == 1) pw_aw = 1;
                if (!pw_w && $urandom_range(0, 1) == 1) pw_w = 1;
            end
            icache_axi_arvalid = pi; icache_axi_araddr = pi_addr; icache_axi_arsize = pi_size;
            dcache_axi_arvalid = pd; dcache_axi_araddr = pd_addr; dcache_axi_arsize = pd_size;
            dcache_axi_awvalid = pw_aw; dcache_axi_awaddr = pw_addr; dcache_axi_awsize = pw_size;
            dcache_axi_wvalid = pw_w; dcache_axi_wdata = pw_data;
            icache_axi_rready = ($urandom_range(0, 3) != 0);
            dcache_axi_rready = ($urandom_range(0, 3) != 0);
            dcache_axi_bready = ($urandom_range(0, 3) != 0);
            m_axi_arready = 1'($urandom_range(0, 1));
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_wready  = 1'($urandom_range(0, 1));
            m_axi_rvalid  = s_rd && (s_rd_dly == 0);
            m_axi_rdata   = s_rd ? s_rdata : $urandom;
            m_axi_bvalid  = s_b && (s_b_dly == 0);
            m_axi_bresp   = s_bresp;
            smp();
            b0 = mb;
            chk("rnd_busy", arb_busy, b0);
            chk("rnd_owner", arb_owner, b0 ? own : 2'b00);
            if (b0 && own != 2'b11) begin
                rv_o = (own == 2'b01) ? icache_axi_rvalid : dcache_axi_rvalid;
                rv_n = (own == 2'b01) ? dcache_axi_rvalid : icache_axi_rvalid;
                rr_o = (own == 2'b01) ? icache_axi_rready : dcache_axi_rready;
                rdat = (own == 2'b01) ? icache_axi_rdata : dcache_axi_rdata;
                chk("rnd_rd_arvalid", m_axi_arvalid, !ar_s);
                chk("rnd_rd_no_wr", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
                if (ar_s) begin
                    chk("rnd_rvalid_owner", rv_o, m_axi_rvalid);
                    chk("rnd_rvalid_other", rv_n, 0);
                    chk("rnd_m_rready", m_axi_rready, rr_o);
                    if (m_axi_rvalid) chk("rnd_rdata", rdat, fmix(m_addr));
                    if (m_axi_rvalid && rr_o) begin
                        mb = 0; s_rd = 0; n_done++;
                    end
                end else begin
                    chk("rnd_rready_early", m_axi_rready, 0);
                    if (m_axi_arready) begin
                        chk("rnd_araddr", m_axi_araddr, m_addr);
                        chk("rnd_arsize", m_axi_arsize, m_size);
                        ar_s = 1; s_rd = 1; s_rd_dly = $urandom_range(0, 3);
                        s_rdata = fmix(m_axi_araddr);
                    end
                end
            end else if (b0) begin
                chk("rnd_wr_no_rd", {m_axi_arvalid, m_axi_rready}, 0);
                if (aw_s && w_s) begin
                    chk("rnd_bvalid", dcache_axi_bvalid, m_axi_bvalid);
                    chk("rnd_m_bready", m_axi_bready, dcache_axi_bready);
                    if (m_axi_bvalid) chk("rnd_bresp", dcache_axi_bresp, s_bresp);
                    if (m_axi_bvalid && dcache_axi_bready) begin
                        mb = 0; s_b = 0; n_done++;
                    end
                end else begin
                    chk("rnd_awvalid", m_axi_awvalid, !aw_s);
                    chk("rnd_wvalid", m_axi_wvalid, !w_s);
                    chk("rnd_bready_early", m_axi_bready, 0);
                    if (!aw_s && m_axi_awready) begin
                        chk("rnd_awaddr", m_axi_awaddr, m_addr);
                        chk("rnd_awsize", m_axi_awsize, m_size);
                        aw_s = 1;
                    end
                    if (!w_s && m_axi_wready) begin
                        chk("rnd_wdata", m_axi_wdata, m_data);
                        w_s = 1;
                    end
                    if (aw_s && w_s) begin
                        s_b = 1; s_b_dly = $urandom_range(0, 3); s_bresp = 2'($urandom_range(0, 3));
                    end
                end
            end else begin
                chk("rnd_idle_master", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
            end
            e_i = 0; e_d = 0; e_w = 0;
            if (!b0) begin
                if (pw_aw && pw_w) e_w = 1;
                else if (pi && pd) begin
                    if (rr_dc) e_i = 1; else e_d = 1;
                end else if (pi) e_i = 1;
                else if (pd) e_d = 1;
            end
            chk("rnd_gnt_ic", icache_axi_arready, e_i);
            chk("rnd_gnt_dc", dcache_axi_arready, e_d);
            chk("rnd_gnt_aw", dcache_axi_awready, e_w);
            chk("rnd_gnt_w", dcache_axi_wready, e_w);
            if (e_w) begin
                mb = 1; own = 2'b11; m_addr = pw_addr; m_size = pw_size; m_data = pw_data;
                pw = 0; pw_aw = 0; pw_w = 0; aw_s = 0; w_s = 0;
            end else if (e_d) begin
                mb = 1; own = 2'b10; m_addr = pd_addr; m_size = pd_size; pd = 0; rr_dc = 1; ar_s = 0;
            end else if (e_i) begin
                mb = 1; own = 2'b01; m_addr = pi_addr; m_size = pi_size; pi = 0; rr_dc = 0; ar_s = 0;
            end
            if (s_rd && s_rd_dly > 0) s_rd_dly--;
            if (s_b && s_b_dly > 0) s_b_dly--;
        end
        chk("rnd_progress", 32'(n_done > 50), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
